// File: rtl/mips_regdest_pkg.sv
// Shared definitions for the register-destination tracker.
// Holds the destination-select codes and the fixed MIPS register numbers
// that the select mux can produce.
package mips_regdest_pkg;

    // Destination select codes; 3'b101..3'b111 mean "no destination"
    typedef enum logic [2:0] {
        REGDEST_RT = 3'b000,
        REGDEST_RD = 3'b001,
        REGDEST_SP = 3'b010,
        REGDEST_FP = 3'b011,
        REGDEST_RA = 3'b100
    } regdest_sel_e;

    // Fixed architectural register numbers
    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 29;
    localparam int unsigned REG_FP   = 30;
    localparam int unsigned REG_RA   = 31;

endpackage : mips_regdest_pkg

// File: rtl/regdest_fifo.sv
// Synchronous FIFO of pending write destinations with per-entry valid bits.
// The caller only asserts i_push/i_pop when legal: i_pop never on empty,
// i_push on full only together with i_pop.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_push, i_din   write i_din at the tail
//   i_pop           remove the head
//   o_head          registered head entry (0 when empty)
//   o_head_valid    FIFO non-empty
//   o_full          count == DEPTH
//   o_count         number of stored entries
//   o_valid         per-slot valid bits
//   o_entries       per-slot stored data
module regdest_fifo #(
    parameter  int unsigned DATA_W = 5,
    parameter  int unsigned DEPTH  = 2,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [DATA_W-1:0]            i_din,
    output logic [DATA_W-1:0]            o_head,
    output logic                         o_head_valid,
    output logic                         o_full,
    output logic [CNT_W-1:0]             o_count,
    output logic [DEPTH-1:0]             o_valid,
    output logic [DEPTH-1:0][DATA_W-1:0] o_entries
);

    logic [PTR_W-1:0]             r_rd_ptr;
    logic [PTR_W-1:0]             r_wr_ptr;
    logic [CNT_W-1:0]             r_count;
    logic [DEPTH-1:0]             r_valid;
    logic [DEPTH-1:0][DATA_W-1:0] r_mem;
    logic [DATA_W-1:0]            r_head;
    logic                         r_head_valid;
    logic                         r_full;

    logic [PTR_W-1:0]             w_rd_ptr_next;
    logic [PTR_W-1:0]             w_wr_ptr_next;
    logic [CNT_W-1:0]             w_count_next;
    logic [DEPTH-1:0]             w_valid_next;
    logic [DEPTH-1:0][DATA_W-1:0] w_mem_next;
    logic [DATA_W-1:0]            w_head_next;

    // Next-state: pop clears the head slot first, so a full push+pop that
    // lands on the same slot leaves it valid with the new data.
    always_comb begin
        w_rd_ptr_next = r_rd_ptr;
        w_wr_ptr_next = r_wr_ptr;
        w_count_next  = r_count;
        w_valid_next  = r_valid;
        w_mem_next    = r_mem;

        if (i_pop) begin
            w_valid_next[r_rd_ptr] = 1'b0;
            w_rd_ptr_next          = r_rd_ptr + PTR_W'(1);
        end
        if (i_push) begin
            w_valid_next[r_wr_ptr] = 1'b1;
            w_mem_next[r_wr_ptr]   = i_din;
            w_wr_ptr_next          = r_wr_ptr + PTR_W'(1);
        end

        case ({i_push, i_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase

        // Head output is precomputed so it is a plain register
        w_head_next = w_valid_next[w_rd_ptr_next] ? w_mem_next[w_rd_ptr_next] : '0;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_valid      <= '0;
            r_mem        <= '0;
            r_head       <= '0;
            r_head_valid <= 1'b0;
            r_full       <= 1'b0;
        end else begin
            r_rd_ptr     <= w_rd_ptr_next;
            r_wr_ptr     <= w_wr_ptr_next;
            r_count      <= w_count_next;
            r_valid      <= w_valid_next;
            r_mem        <= w_mem_next;
            r_head       <= w_head_next;
            r_head_valid <= (w_count_next != '0);
            r_full       <= (w_count_next == CNT_W'(DEPTH));
        end
    end

    assign o_head       = r_head;
    assign o_head_valid = r_head_valid;
    assign o_full       = r_full;
    assign o_count      = r_count;
    assign o_valid      = r_valid;
    assign o_entries    = r_mem;

endmodule : regdest_fifo

// File: rtl/reg_dest_tracker.sv
// Register-destination tracker for the multicycle MIPS datapath.
// Selects the write destination (RT, RD, SP, FP, RA), queues destinations of
// in-flight instructions and presents the oldest to the register file, while
// flagging RAW hazards of two source operands against all pending entries.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   seletor_regdest   destination select code
//   RT, RD            instruction register fields
//   issue             capture the selected destination
//   wb_done           oldest destination written back
//   src_a, src_b      source operands for hazard compare
//   regDest_output    oldest pending destination (0 when empty)
//   dest_valid        regDest_output valid
//   hazard_a/b        combinational: source matches a pending destination
//   full              pending_count == MAX_PENDING
//   pending_count     number of in-flight destinations
//   err               sticky overflow/underflow flag
module reg_dest_tracker
    import mips_regdest_pkg::*;
#(
    parameter  int unsigned REG_ADDR_W  = 5,
    parameter  int unsigned MAX_PENDING = 2,
    localparam int unsigned CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            seletor_regdest,
    input  logic [REG_ADDR_W-1:0] RT,
    input  logic [REG_ADDR_W-1:0] RD,
    input  logic                  issue,
    input  logic                  wb_done,
    input  logic [REG_ADDR_W-1:0] src_a,
    input  logic [REG_ADDR_W-1:0] src_b,
    output logic [REG_ADDR_W-1:0] regDest_output,
    output logic                  dest_valid,
    output logic                  hazard_a,
    output logic                  hazard_b,
    output logic                  full,
    output logic [CNT_W-1:0]      pending_count,
    output logic                  err
);

    logic [REG_ADDR_W-1:0]                  w_sel_dest;
    logic                                   w_sel_some;
    logic                                   w_push_req;
    logic                                   w_empty;
    logic                                   w_push;
    logic                                   w_pop;
    logic                                   w_overflow;
    logic                                   w_underflow;
    logic                                   w_full;
    logic [CNT_W-1:0]                       w_count;
    logic [MAX_PENDING-1:0]                 w_valid;
    logic [MAX_PENDING-1:0][REG_ADDR_W-1:0] w_entries;
    logic                                   r_err;

    // Destination select mux
    always_comb begin
        w_sel_dest = '0;
        w_sel_some = 1'b1;
        case (seletor_regdest)
            REGDEST_RT: w_sel_dest = RT;
            REGDEST_RD: w_sel_dest = RD;
            REGDEST_SP: w_sel_dest = REG_ADDR_W'(REG_SP);
            REGDEST_FP: w_sel_dest = REG_ADDR_W'(REG_FP);
            REGDEST_RA: w_sel_dest = REG_ADDR_W'(REG_RA);
            default:    w_sel_some = 1'b0;
        endcase
    end

    // Writes to $zero are discarded silently, never queued
    assign w_push_req  = issue && w_sel_some && (w_sel_dest != REG_ADDR_W'(REG_ZERO));
    assign w_empty     = (w_count == '0);
    assign w_pop       = wb_done && !w_empty;
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_overflow  = w_push_req && w_full && !wb_done;
    assign w_underflow = wb_done && w_empty;

    regdest_fifo #(
        .DATA_W (REG_ADDR_W),
        .DEPTH  (MAX_PENDING)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_din        (w_sel_dest),
        .o_head       (regDest_output),
        .o_head_valid (dest_valid),
        .o_full       (w_full),
        .o_count      (w_count),
        .o_valid      (w_valid),
        .o_entries    (w_entries)
    );

    // Sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_overflow || w_underflow) begin
            r_err <= 1'b1;
        end
    end

    // RAW compare against entries valid this cycle; $zero never conflicts
    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int i = 0; i < int'(MAX_PENDING); i++) begin
            if (w_valid[i] && (src_a != '0) && (w_entries[i] == src_a)) begin
                hazard_a = 1'b1;
            end
            if (w_valid[i] && (src_b != '0) && (w_entries[i] == src_b)) begin
                hazard_b = 1'b1;
            end
        end
    end

    assign full          = w_full;
    assign pending_count = w_count;
    assign err           = r_err;

endmodule : reg_dest_tracker

// File: tb/tb_reg_dest_tracker.sv
// Self-checking bench for reg_dest_tracker: directed table, a hand-written
// full-FIFO streaming sequence, and randomized traffic against a queue model.
module tb_reg_dest_tracker;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned MAX_PENDING = 2;
    localparam int unsigned CNT_W       = $clog2(MAX_PENDING + 1);

    logic                  clk = 1'b0;
    logic                  reset;
    logic [2:0]            seletor_regdest;
    logic [REG_ADDR_W-1:0] RT, RD, src_a, src_b;
    logic                  issue, wb_done;
    logic [REG_ADDR_W-1:0] regDest_output;
    logic                  dest_valid, hazard_a, hazard_b, full, err;
    logic [CNT_W-1:0]      pending_count;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    int q[$];
    int m_err;

    reg_dest_tracker #(
        .REG_ADDR_W  (REG_ADDR_W),
        .MAX_PENDING (MAX_PENDING)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .seletor_regdest (seletor_regdest),
        .RT              (RT),
        .RD              (RD),
        .issue           (issue),
        .wb_done         (wb_done),
        .src_a           (src_a),
        .src_b           (src_b),
        .regDest_output  (regDest_output),
        .dest_valid      (dest_valid),
        .hazard_a        (hazard_a),
        .hazard_b        (hazard_b),
        .full            (full),
        .pending_count   (pending_count),
        .err             (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rst, sel, rt, rd, iss, wb, sa, sb;
        int ha, hb;
        int head, dv, cnt, fl, er;
    } vec_t;

    vec_t tbl[26];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int rst, input int sel, input int rt, input int rd,
                         input int iss, input int wb, input int sa, input int sb);
        reset           = rst[0];
        seletor_regdest = sel[2:0];
        RT              = rt[4:0];
        RD              = rd[4:0];
        issue           = iss[0];
        wb_done         = wb[0];
        src_a           = sa[4:0];
        src_b           = sb[4:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag, input int head, input int dv,
                            input int cnt, input int fl, input int er);
        chk({tag, ".head"},  int'(regDest_output), head);
        chk({tag, ".valid"}, int'(dest_valid),     dv);
        chk({tag, ".count"}, int'(pending_count),  cnt);
        chk({tag, ".full"},  int'(full),           fl);
        chk({tag, ".err"},   int'(err),            er);
    endtask

    // Model: destination from the select code, by the architectural map
    function automatic int model_dest(input int sel, input int rt, input int rd);
        case (sel)
            0:       return rt;
            1:       return rd;
            2:       return 29;
            3:       return 30;
            4:       return 31;
            default: return 0;
        endcase
    endfunction

    function automatic int model_haz(input int src);
        if (src == 0) return 0;
        foreach (q[i]) if (q[i] == src) return 1;
        return 0;
    endfunction

    task automatic model_step(input int rst, input int sel, input int rt, input int rd,
                              input int iss, input int wb);
        int d;
        bit was_empty, was_full;
        if (rst != 0) begin
            q.delete();
            m_err = 0;
            return;
        end
        d         = model_dest(sel, rt, rd);
        was_empty = (q.size() == 0);
        was_full  = (q.size() == int'(MAX_PENDING));
        if (wb != 0 && was_empty) m_err = 1;
        if (iss != 0 && d != 0 && was_full && wb == 0) m_err = 1;
        if (wb != 0 && !was_empty) void'(q.pop_front());
        if (iss != 0 && d != 0 && !(was_full && wb == 0)) q.push_back(d);
    endtask

    initial begin
        // rst sel rt rd iss wb sa sb | ha hb | head dv cnt full err
        tbl[0]  = '{0,0,0,0,0,0,0,0,    0,0,  0,0,0,0,0};
        tbl[1]  = '{0,1,0,8,1,0,8,9,    0,0,  8,1,1,0,0};
        tbl[2]  = '{0,0,0,0,0,0,8,9,    1,0,  8,1,1,0,0};
        tbl[3]  = '{0,0,0,0,0,1,8,9,    1,0,  0,0,0,0,0};
        tbl[4]  = '{0,0,0,0,0,0,8,9,    0,0,  0,0,0,0,0};
        tbl[5]  = '{0,4,0,0,1,0,0,0,    0,0,  31,1,1,0,0};
        tbl[6]  = '{0,0,5,0,1,0,31,5,   1,0,  31,1,2,1,0};
        tbl[7]  = '{0,1,0,7,1,0,5,7,    1,0,  31,1,2,1,1};
        tbl[8]  = '{0,1,0,12,1,1,12,31, 0,1,  5,1,2,1,1};
        tbl[9]  = '{0,0,0,0,0,1,12,5,   1,1,  12,1,1,0,1};
        tbl[10] = '{0,0,0,0,0,1,12,0,   1,0,  0,0,0,0,1};
        tbl[11] = '{1,0,0,0,0,0,0,0,    0,0,  0,0,0,0,0};
        tbl[12] = '{0,0,0,0,1,0,0,0,    0,0,  0,0,0,0,0};
        tbl[13] = '{0,7,3,3,1,0,3,3,    0,0,  0,0,0,0,0};
        tbl[14] = '{0,2,0,0,1,0,0,29,   0,0,  29,1,1,0,0};
        tbl[15] = '{0,3,0,0,1,0,29,0,   1,0,  29,1,2,1,0};
        tbl[16] = '{0,0,0,0,0,0,30,29,  1,1,  29,1,2,1,0};
        tbl[17] = '{1,0,0,0,0,0,30,0,   1,0,  0,0,0,0,0};
        tbl[18] = '{0,0,0,0,0,1,0,0,    0,0,  0,0,0,0,1};
        tbl[19] = '{1,0,0,0,0,0,0,0,    0,0,  0,0,0,0,0};
        tbl[20] = '{0,1,0,9,1,1,9,0,    0,0,  9,1,1,0,1};
        tbl[21] = '{0,1,0,9,1,0,9,0,    1,0,  9,1,2,1,1};
        tbl[22] = '{0,0,0,0,0,1,9,0,    1,0,  9,1,1,0,1};
        tbl[23] = '{0,0,0,0,0,0,9,0,    1,0,  9,1,1,0,1};
        tbl[24] = '{0,0,0,0,0,1,9,0,    1,0,  0,0,0,0,1};
        tbl[25] = '{0,0,0,0,0,0,9,0,    0,0,  0,0,0,0,1};

        // Initial reset
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_regs("reset", 0, 0, 0, 0, 0);
        chk("reset.haz_a", int'(hazard_a), 0);
        chk("reset.haz_b", int'(hazard_b), 0);

        // Directed table
        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].rst, tbl[i].sel, tbl[i].rt, tbl[i].rd,
                  tbl[i].iss, tbl[i].wb, tbl[i].sa, tbl[i].sb);
            #2;
            chk($sformatf("tbl%0d.haz_a", i), int'(hazard_a), tbl[i].ha);
            chk($sformatf("tbl%0d.haz_b", i), int'(hazard_b), tbl[i].hb);
            tick();
            chk_regs($sformatf("tbl%0d", i), tbl[i].head, tbl[i].dv,
                     tbl[i].cnt, tbl[i].fl, tbl[i].er);
        end

        // Streaming through a full FIFO: issue+wb each cycle keeps it full
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 1, 1, 0, 0, 0);
        tick();
        drive(0, 1, 0, 2, 1, 0, 0, 0);
        tick();
        chk_regs("stream.fill", 1, 1, 2, 1, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 3 + k, 1, 1, 0, 0);
            tick();
            chk_regs($sformatf("stream%0d", k), 2 + k, 1, 2, 1, 0);
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        chk_regs("stream.drain1", 5, 1, 1, 0, 0);
        tick();
        chk_regs("stream.drain2", 0, 0, 0, 0, 0);

        // Randomized traffic against the queue model
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        q.delete();
        m_err = 0;
        for (int c = 0; c < 2000; c++) begin
            int rst, sel, rt, rd, iss, wb, sa, sb, hd;
            rst = ($urandom_range(0, 99) == 0) ? 1 : 0;
            sel = int'($urandom_range(0, 7));
            rt  = int'($urandom_range(0, 7));
            rd  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            iss = int'($urandom_range(0, 1));
            wb  = int'($urandom_range(0, 1));
            sa  = int'($urandom_range(0, 7));
            sb  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(28, 31));
            drive(rst, sel, rt, rd, iss, wb, sa, sb);
            #2;
            chk("rnd.haz_a", int'(hazard_a), model_haz(sa));
            chk("rnd.haz_b", int'(hazard_b), model_haz(sb));
            tick();
            model_step(rst, sel, rt, rd, iss, wb);
            hd = (q.size() > 0) ? q[0] : 0;
            chk_regs("rnd", hd, (q.size() > 0) ? 1 : 0, q.size(),
                     (q.size() == int'(MAX_PENDING)) ? 1 : 0, m_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_reg_dest_tracker
